// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit Fibonacci LFSR word stream and its receive-side checker.
package lfsr_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'h1f;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // One single-bit shift: feedback from taps 4 and 1 enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] d);
    return {d[4] ^ d[1], d[4:1]};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step_n(input logic [LFSR_W-1:0] d, input int n);
    logic [LFSR_W-1:0] r;
    r = d;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

endpackage

// File: rtl/lfsr_next_word.sv
// Combinational word-level LFSR advance: BITS single-bit steps applied to one word.
module lfsr_next_word
  import lfsr_pkg::*;
#(
  parameter int BITS = 5
) (
  input  logic [LFSR_W-1:0] data_i,
  output logic [LFSR_W-1:0] data_o
);

  always_comb data_o = lfsr_step_n(data_i, BITS);

endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the LFSR word stream: predicts each word, acquires and holds lock,
// flywheels through isolated errors, counts locked-state mismatches and flags the all-zero word.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int BITS       = 5,
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic              zero_stuck,
  output logic [LFSR_W-1:0] expected_data
);

  localparam int MR_W = $clog2(LOCK_COUNT + 1);
  localparam int MS_W = $clog2(LOSS_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e        state_q, state_d;
  logic              have_prev_q, have_prev_d;
  logic [LFSR_W-1:0] prev_word_q, prev_word_d;
  logic [MR_W-1:0]   match_run_q, match_run_d;
  logic [MS_W-1:0]   miss_run_q, miss_run_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              zero_stuck_q, zero_stuck_d;
  logic [LFSR_W-1:0] expected_q, expected_d;
  logic [LFSR_W-1:0] pred;
  logic              zero_word, err_hit;

  lfsr_next_word #(.BITS(BITS)) u_pred (
    .data_i (prev_word_q),
    .data_o (pred)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    prev_word_d = prev_word_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_hit     = 1'b0;
    zero_word   = in_valid && (in_data == '0);

    if (in_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (zero_word) begin
            have_prev_d = 1'b0;
            match_run_d = '0;
          end else begin
            prev_word_d = in_data;
            if (!have_prev_q) begin
              have_prev_d = 1'b1;
            end else if (in_data == pred) begin
              if (int'(match_run_q) + 1 == LOCK_COUNT) begin
                state_d     = LOCKED;
                match_run_d = '0;
                miss_run_d  = '0;
              end else begin
                match_run_d = match_run_q + 1'b1;
              end
            end else begin
              match_run_d = '0;
            end
          end
        end
        LOCKED: begin
          // A zero word is a mismatch even if the prediction itself collapsed to zero.
          if (!zero_word && in_data == pred) begin
            miss_run_d  = '0;
            prev_word_d = in_data;
          end else begin
            err_hit = 1'b1;
            if (int'(miss_run_q) + 1 == LOSS_COUNT) begin
              state_d     = SEARCH;
              match_run_d = '0;
              miss_run_d  = '0;
              prev_word_d = in_data;
              have_prev_d = !zero_word;
            end else begin
              miss_run_d  = miss_run_q + 1'b1;
              prev_word_d = pred;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clear_cnt)                          err_count_d = err_hit ? CNT_W'(1) : '0;
    else if (err_hit && err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
    else                                    err_count_d = err_count_q;

    zero_stuck_d = zero_word || (zero_stuck_q && !clear_cnt);
    err_pulse_d  = err_hit;
    expected_d   = lfsr_step_n(prev_word_d, BITS);
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      have_prev_q  <= 1'b0;
      prev_word_q  <= '0;
      match_run_q  <= '0;
      miss_run_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      zero_stuck_q <= 1'b0;
      expected_q   <= '0;
    end else begin
      state_q      <= state_d;
      have_prev_q  <= have_prev_d;
      prev_word_q  <= prev_word_d;
      match_run_q  <= match_run_d;
      miss_run_q   <= miss_run_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      zero_stuck_q <= zero_stuck_d;
      expected_q   <= expected_d;
    end
  end

  assign locked        = (state_q == LOCKED);
  assign err_pulse     = err_pulse_q;
  assign err_count     = err_count_q;
  assign zero_stuck    = zero_stuck_q;
  assign expected_data = expected_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: directed scenarios plus randomized traffic
// compared against an integer-level reference model of the checker rules.
module tb_lfsr_seq_checker;
  import lfsr_pkg::*;

  localparam int LOCK = 3;
  localparam int LOSS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_data = '0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_pulse, zero_stuck;
  logic [15:0] err_count;
  logic [4:0]  expected_data;
  logic        s_locked, s_err_pulse, s_zero_stuck;
  logic [1:0]  s_err_count;
  logic [4:0]  s_expected_data;

  int n_assert = 0;
  int n_fail   = 0;
  string cur_step = "init";

  // Reference model state
  bit m_locked, m_have, m_zs, m_pulse;
  int m_prev, m_mrun, m_miss, m_cnt16, m_cnt2, m_exp;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.BITS(5), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .zero_stuck(zero_stuck), .expected_data(expected_data)
  );

  lfsr_seq_checker #(.BITS(5), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .zero_stuck(s_zero_stuck), .expected_data(s_expected_data)
  );

  // Five single-bit shifts: bit 4 receives bit4 xor bit1, everything else moves down one place.
  function automatic int ref_next(input int d);
    int x, fb;
    x = d;
    for (int k = 0; k < 5; k++) begin
      fb = ((x >> 4) ^ (x >> 1)) & 1;
      x  = (x >> 1) | (fb << 4);
    end
    return x & 31;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", cur_step, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("locked",        32'(locked),          32'(m_locked));
    check("err_pulse",     32'(err_pulse),       32'(m_pulse));
    check("err_count",     32'(err_count),       m_cnt16);
    check("zero_stuck",    32'(zero_stuck),      32'(m_zs));
    check("expected_data", 32'(expected_data),   m_exp);
    check("sat_err_count", 32'(s_err_count),     m_cnt2);
    check("sat_locked",    32'(s_locked),        32'(m_locked));
    check("sat_zero",      32'(s_zero_stuck),    32'(m_zs));
  endtask

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_zs = 0; m_pulse = 0;
    m_prev = 0; m_mrun = 0; m_miss = 0; m_cnt16 = 0; m_cnt2 = 0; m_exp = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit err;
    int p;
    err = 0;
    if (v) begin
      if (!m_locked) begin
        if (d == 0) begin
          m_have = 0;
          m_mrun = 0;
        end else begin
          if (!m_have) m_have = 1;
          else if (d == ref_next(m_prev)) begin
            if (m_mrun + 1 == LOCK) begin
              m_locked = 1; m_mrun = 0; m_miss = 0;
            end else m_mrun++;
          end else m_mrun = 0;
          m_prev = d;
        end
      end else begin
        p = ref_next(m_prev);
        if (d != 0 && d == p) begin
          m_miss = 0;
          m_prev = d;
        end else begin
          err = 1;
          m_miss++;
          if (m_miss == LOSS) begin
            m_locked = 0; m_mrun = 0; m_miss = 0; m_prev = d; m_have = (d != 0);
          end else m_prev = p;
        end
      end
    end
    if (c) begin
      m_cnt16 = err ? 1 : 0;
      m_cnt2  = err ? 1 : 0;
    end else if (err) begin
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
    if (v && d == 0) m_zs = 1;
    else if (c)      m_zs = 0;
    m_pulse = err;
    m_exp   = ref_next(m_prev);
  endtask

  task automatic word(input bit v, input int d, input bit c);
    in_valid  = v;
    in_data   = 5'(d);
    clear_cnt = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear_cnt = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  task automatic acquire();
    word(1, int'(LFSR_SEED), 0);
    word(1, 'h1A, 0);
    word(1, 'h04, 0);
    word(1, 'h1E, 0);
  endtask

  initial begin
    int r, d, pr;
    bit v, c;

    cur_step = "reset";
    do_reset();
    do_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_expected", 32'(expected_data), 0);

    cur_step = "acquire";
    acquire();
    check("acq_locked", 32'(locked), 1);
    check("acq_expected", 32'(expected_data), 'h1A);
    check("acq_count", 32'(err_count), 0);

    cur_step = "single_err";
    word(1, 'h1A, 0);
    word(1, 'h05, 0);
    check("se_pulse", 32'(err_pulse), 1);
    check("se_count", 32'(err_count), 1);
    check("se_locked", 32'(locked), 1);
    word(1, 'h1E, 0);
    check("se_match_pulse", 32'(err_pulse), 0);

    cur_step = "loss";
    do_reset();
    acquire();
    word(1, 'h1A, 0);
    word(1, 'h07, 0);
    check("loss_still_locked", 32'(locked), 1);
    word(1, 'h07, 0);
    check("loss_count", 32'(err_count), 2);
    check("loss_locked", 32'(locked), 0);
    word(1, 'h1A, 0);
    word(1, 'h04, 0);
    word(1, 'h1E, 0);
    check("relock_pending", 32'(locked), 0);
    word(1, 'h1A, 0);
    check("relock", 32'(locked), 1);

    cur_step = "zero";
    do_reset();
    word(1, 'h00, 0);
    check("zero_stuck_set", 32'(zero_stuck), 1);
    word(1, int'(LFSR_SEED), 0);
    word(1, 'h1A, 0);
    check("zero_no_lock", 32'(locked), 0);
    word(0, 'h00, 1);
    check("zero_cleared", 32'(zero_stuck), 0);
    word(1, 'h00, 1);
    check("zero_set_wins", 32'(zero_stuck), 1);
    word(0, 'h00, 0);

    cur_step = "clear_sat";
    do_reset();
    acquire();
    for (int i = 0; i < 5; i++) begin
      word(1, ref_next(m_prev) ^ 'h01, 0);
      word(1, ref_next(m_prev), 0);
    end
    check("five_errs", 32'(err_count), 5);
    check("sat_at_3", 32'(s_err_count), 3);
    word(1, ref_next(m_prev) ^ 'h03, 1);
    check("clr_with_err", 32'(err_count), 1);
    check("sat_clr_with_err", 32'(s_err_count), 1);
    word(0, 'h15, 0);
    check("idle_pulse", 32'(err_pulse), 0);
    word(0, 'h00, 1);
    check("clr_plain", 32'(err_count), 0);

    cur_step = "rst_mid";
    word(1, ref_next(m_prev), 0);
    check("pre_rst_locked", 32'(locked), 1);
    do_reset();
    check("mid_rst_locked", 32'(locked), 0);
    word(1, 'h1A, 0);
    check("seed_only", 32'(locked), 0);
    word(1, 'h04, 0);
    word(1, 'h1E, 0);
    word(1, 'h1A, 0);
    check("mid_rst_relock", 32'(locked), 1);

    cur_step = "random";
    for (int i = 0; i < 800; i++) begin
      r  = int'($urandom_range(0, 99));
      v  = (r >= 10);
      pr = ref_next(m_prev);
      r  = int'($urandom_range(0, 99));
      if (r < 70)      d = pr;
      else if (r < 76) d = 0;
      else             d = int'($urandom_range(1, 31));
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 249) == 0) do_reset();
      else word(v, d, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
